// File: rtl/baccarat_deal_ctrl.sv
// Baccarat deal sequencer: steps the card-register load strobes one card per request,
// applies the third-card rules on the live hand scores and latches the winner lights.
module baccarat_deal_ctrl #(
    parameter int unsigned NATURAL_MIN      = 8,
    parameter int unsigned PLAYER_STAND_MIN = 6
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_cards,
    output logic       waiting,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    localparam logic [3:0] NAT_MIN   = 4'(NATURAL_MIN);
    localparam logic [3:0] STAND_MIN = 4'(PLAYER_STAND_MIN);

    typedef enum logic [3:0] {
        WAIT_P1, LD_P1, WAIT_D1, LD_D1, WAIT_P2, LD_P2, WAIT_D2, LD_D2,
        EVAL2, WAIT_P3, LD_P3, EVAL3, WAIT_D3, LD_D3, RESULT, DONE
    } state_t;

    state_t     state_q, state_d;
    logic       clear_q, clear_d;
    logic       pwin_q, pwin_d;
    logic       dwin_q, dwin_d;
    logic       waiting_q, waiting_d;
    logic [5:0] load_q, load_d;
    logic [3:0] pcard3_val;
    logic       dealer_draws;

    // Face cards and tens count as zero in the drawing table.
    assign pcard3_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

    always_comb begin
        dealer_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (pcard3_val != 4'd8);
            4'd4:             dealer_draws = (pcard3_val >= 4'd2) && (pcard3_val <= 4'd7);
            4'd5:             dealer_draws = (pcard3_val >= 4'd4) && (pcard3_val <= 4'd7);
            4'd6:             dealer_draws = (pcard3_val == 4'd6) || (pcard3_val == 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        pwin_d  = pwin_q;
        dwin_d  = dwin_q;
        case (state_q)
            WAIT_P1: if (step) state_d = LD_P1;
            LD_P1:   state_d = WAIT_D1;
            WAIT_D1: if (step) state_d = LD_D1;
            LD_D1:   state_d = WAIT_P2;
            WAIT_P2: if (step) state_d = LD_P2;
            LD_P2:   state_d = WAIT_D2;
            WAIT_D2: if (step) state_d = LD_D2;
            LD_D2:   state_d = EVAL2;
            EVAL2: begin
                if (pscore >= NAT_MIN || dscore >= NAT_MIN) state_d = RESULT;
                else if (pscore < STAND_MIN)                state_d = WAIT_P3;
                else if (dscore <= 4'd5)                    state_d = WAIT_D3;
                else                                        state_d = RESULT;
            end
            WAIT_P3: if (step) state_d = LD_P3;
            LD_P3:   state_d = EVAL3;
            EVAL3:   state_d = dealer_draws ? WAIT_D3 : RESULT;
            WAIT_D3: if (step) state_d = LD_D3;
            LD_D3:   state_d = RESULT;
            RESULT: begin
                state_d = DONE;
                pwin_d  = (pscore >= dscore);
                dwin_d  = (dscore >= pscore);
            end
            DONE: begin
                if (step) begin
                    state_d = WAIT_P1;
                    clear_d = 1'b1;
                    pwin_d  = 1'b0;
                    dwin_d  = 1'b0;
                end
            end
            default: state_d = WAIT_P1;
        endcase
    end

    // Strobes are decoded from the next state so each one is registered yet
    // coincides exactly with the cycle spent in its LD state.
    always_comb begin
        load_d    = '0;
        load_d[0] = (state_d == LD_P1);
        load_d[1] = (state_d == LD_P2);
        load_d[2] = (state_d == LD_P3);
        load_d[3] = (state_d == LD_D1);
        load_d[4] = (state_d == LD_D2);
        load_d[5] = (state_d == LD_D3);
        waiting_d = (state_d == WAIT_P1) || (state_d == WAIT_D1) || (state_d == WAIT_P2) ||
                    (state_d == WAIT_D2) || (state_d == WAIT_P3) || (state_d == WAIT_D3) ||
                    (state_d == DONE);
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q   <= WAIT_P1;
            load_q    <= '0;
            clear_q   <= 1'b0;
            pwin_q    <= 1'b0;
            dwin_q    <= 1'b0;
            waiting_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            clear_q   <= clear_d;
            pwin_q    <= pwin_d;
            dwin_q    <= dwin_d;
            waiting_q <= waiting_d;
        end
    end

    assign load_pcard1      = load_q[0];
    assign load_pcard2      = load_q[1];
    assign load_pcard3      = load_q[2];
    assign load_dcard1      = load_q[3];
    assign load_dcard2      = load_q[4];
    assign load_dcard3      = load_q[5];
    assign clear_cards      = clear_q;
    assign waiting          = waiting_q;
    assign player_win_light = pwin_q;
    assign dealer_win_light = dwin_q;

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Self-checking bench for baccarat_deal_ctrl: strobe and light expectations are queued
// as stimulus is driven and popped when the controller responds.
module tb_baccarat_deal_ctrl;

    logic       slow_clock = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic [3:0] pscore = '0;
    logic [3:0] dscore = '0;
    logic [3:0] pcard3 = '0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       clear_cards, waiting, player_win_light, dealer_win_light;

    baccarat_deal_ctrl #(.NATURAL_MIN(8), .PLAYER_STAND_MIN(6)) dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .clear_cards      (clear_cards),
        .waiting          (waiting),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    always #5 slow_clock = ~slow_clock;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_P1   = 7'b0000001;
    localparam logic [6:0] S_P2   = 7'b0000010;
    localparam logic [6:0] S_P3   = 7'b0000100;
    localparam logic [6:0] S_D1   = 7'b0001000;
    localparam logic [6:0] S_D2   = 7'b0010000;
    localparam logic [6:0] S_D3   = 7'b0100000;
    localparam logic [6:0] S_CLR  = 7'b1000000;

    logic [6:0] strobes;
    assign strobes = {clear_cards, load_dcard3, load_dcard2, load_dcard1,
                      load_pcard3, load_pcard2, load_pcard1};

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];
    logic [1:0] light_q[$];

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic step_cycle(output logic [6:0] obs);
        step = 1'b1;
        tick();
        step = 1'b0;
        obs = strobes;
    endtask

    // Advances until waiting rises (bounded), OR-ing every strobe seen on the way.
    task automatic wait_waiting(output logic [6:0] acc, output bit ok);
        bit done;
        acc  = '0;
        ok   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            tick();
            acc = acc | strobes;
            if (waiting === 1'b1) begin
                ok   = 1'b1;
                done = 1'b1;
            end
        end
    endtask

    function automatic bit model_dealer_draws(int d, int code);
        int v;
        v = (code >= 10) ? 0 : code;
        if (d <= 2)  return 1'b1;
        if (d == 3)  return v != 8;
        if (d == 4)  return (v >= 2) && (v <= 7);
        if (d == 5)  return (v >= 4) && (v <= 7);
        if (d == 6)  return (v == 6) || (v == 7);
        return 1'b0;
    endfunction

    // Plays one full round: two-card totals p2/d2, player third card c3, and the
    // totals pf/df that the scoring logic would show after each third card.
    task automatic play_round(input string tag, input int p2, input int d2, input int c3,
                              input int pf, input int df);
        logic [6:0] obs, acc, e;
        logic [1:0] el, ol;
        bit ok, natural, pdraw, ddraw;
        int pfin, dfin;
        pscore = '0;
        dscore = '0;
        pcard3 = '0;
        exp_q.push_back(S_P1);
        exp_q.push_back(S_D1);
        exp_q.push_back(S_P2);
        exp_q.push_back(S_D2);
        for (int k = 0; k < 4; k++) begin
            step_cycle(obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s deal%0d: strobes=%b required %b", tag, k, obs, e);
            end
            if (k == 3) begin
                pscore = 4'(p2);
                dscore = 4'(d2);
            end
            wait_waiting(acc, ok);
            n_checks++;
            if (acc !== S_NONE || !ok) begin
                n_fail++;
                $display("FAIL %s idle%0d: stray strobes=%b waiting_seen=%0d required 0000000/1",
                         tag, k, acc, ok);
            end
        end
        natural = (p2 >= 8) || (d2 >= 8);
        pdraw   = !natural && (p2 < 6);
        ddraw   = !natural && (pdraw ? model_dealer_draws(d2, c3) : (d2 <= 5));
        if (pdraw) exp_q.push_back(S_P3);
        if (ddraw) exp_q.push_back(S_D3);
        pfin = pdraw ? pf : p2;
        dfin = ddraw ? df : d2;
        el = (pfin > dfin) ? 2'b10 : (pfin < dfin) ? 2'b01 : 2'b11;
        light_q.push_back(el);
        while (exp_q.size() > 0) begin
            step_cycle(obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s third: strobes=%b required %b", tag, obs, e);
            end
            if (e == S_P3) begin
                pcard3 = 4'(c3);
                pscore = 4'(pf);
            end else begin
                dscore = 4'(df);
            end
            wait_waiting(acc, ok);
            n_checks++;
            if (acc !== S_NONE || !ok) begin
                n_fail++;
                $display("FAIL %s third_idle: stray strobes=%b waiting_seen=%0d required 0000000/1",
                         tag, acc, ok);
            end
        end
        ol = {player_win_light, dealer_win_light};
        el = light_q.pop_front();
        n_checks++;
        if (ol !== el) begin
            n_fail++;
            $display("FAIL %s lights: p/d=%b required %b (p=%0d d=%0d)", tag, ol, el, pfin, dfin);
        end
        // Scores wander in DONE; the lights must not follow them.
        pscore = 4'(9 - pfin);
        dscore = 4'(9 - dfin);
        tick();
        n_checks++;
        if ({player_win_light, dealer_win_light} !== el || strobes !== S_NONE) begin
            n_fail++;
            $display("FAIL %s hold: p/d=%b strobes=%b required %b/0000000",
                     tag, {player_win_light, dealer_win_light}, strobes, el);
        end
        step_cycle(obs);
        n_checks++;
        if (obs !== S_CLR || {player_win_light, dealer_win_light} !== 2'b00 || waiting !== 1'b1) begin
            n_fail++;
            $display("FAIL %s clear: strobes=%b lights=%b waiting=%b required %b/00/1",
                     tag, obs, {player_win_light, dealer_win_light}, waiting, S_CLR);
        end
        tick();
        n_checks++;
        if (strobes !== S_NONE || waiting !== 1'b1) begin
            n_fail++;
            $display("FAIL %s post_clear: strobes=%b waiting=%b required 0000000/1",
                     tag, strobes, waiting);
        end
        $display("round %s: p2=%0d d2=%0d c3=%0d final p=%0d d=%0d lights=%b", tag, p2, d2, c3,
                 pfin, dfin, el);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step  = 1'b1;
        tick();
        tick();
        n_checks++;
        if (strobes !== S_NONE || waiting !== 1'b1 ||
            {player_win_light, dealer_win_light} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset: strobes=%b waiting=%b lights=%b required 0000000/1/00",
                     strobes, waiting, {player_win_light, dealer_win_light});
        end
        reset = 1'b0;
        step  = 1'b0;
        tick();
        n_checks++;
        if (strobes !== S_NONE || waiting !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: strobes=%b waiting=%b required 0000000/1", strobes, waiting);
        end
        $display("reset: strobes=%b waiting=%b", strobes, waiting);
    endtask

    task automatic test_back_to_back();
        logic [6:0] e;
        exp_q.push_back(S_P1); exp_q.push_back(S_NONE);
        exp_q.push_back(S_D1); exp_q.push_back(S_NONE);
        exp_q.push_back(S_P2); exp_q.push_back(S_NONE);
        exp_q.push_back(S_D2); exp_q.push_back(S_NONE);
        step = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (strobes !== e) begin
                n_fail++;
                $display("FAIL back_to_back%0d: strobes=%b required %b", i, strobes, e);
            end
            $display("back_to_back cycle %0d: strobes=%b", i, strobes);
        end
        step  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (strobes !== S_NONE || waiting !== 1'b1) begin
            n_fail++;
            $display("FAIL abort: strobes=%b waiting=%b required 0000000/1", strobes, waiting);
        end
    endtask

    task automatic test_reset_mid_round();
        logic [6:0] obs, acc;
        bit ok;
        step_cycle(obs);
        wait_waiting(acc, ok);
        step_cycle(obs);
        wait_waiting(acc, ok);
        step  = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        step  = 1'b0;
        n_checks++;
        if (strobes !== S_NONE || waiting !== 1'b1 ||
            {player_win_light, dealer_win_light} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid: strobes=%b waiting=%b lights=%b required 0000000/1/00",
                     strobes, waiting, {player_win_light, dealer_win_light});
        end
        tick();
        n_checks++;
        if (strobes !== S_NONE) begin
            n_fail++;
            $display("FAIL reset_mid_after: strobes=%b required 0000000", strobes);
        end
        step_cycle(obs);
        n_checks++;
        if (obs !== S_P1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: strobes=%b required %b", obs, S_P1);
        end
        $display("reset mid-round: restart strobes=%b", obs);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed_rounds();
        play_round("natural",       8, 3, 0, 0, 0);
        play_round("both_draw",     5, 6, 7, 2, 9);
        play_round("dealer_stands", 4, 3, 8, 3, 0);
        play_round("player_stands", 6, 5, 0, 0, 1);
        play_round("stand_vs_7",    6, 7, 0, 0, 0);
        play_round("dealer_nat",    2, 9, 0, 0, 0);
    endtask

    task automatic test_random_rounds();
        for (int r = 0; r < 24; r++) begin
            play_round($sformatf("rand%0d", r), int'($urandom_range(0, 9)),
                       int'($urandom_range(0, 9)), int'($urandom_range(0, 13)),
                       int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_reset_mid_round();
        test_directed_rounds();
        test_random_rounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
